video_timing_gen: RTL and testbench
===================================

Name: video_timing_gen

Overview:
Parametrised raster timing generator that supersedes the fixed-geometry system clock/sync block and the ad-hoc 4H delay-tap flops in the graphics benches.
- Produces H/V counters, sync, blanking, a vertical-blank interrupt with acknowledge handshake, a frame counter, and a configurable chain of delayed phase taps.
- Runs on the single fast system clock and advances only on pixel-enable cycles (the MCKR-rate strobe).
- Feeds the graphics pipeline, motion-object and playfield logic, and the 68k interrupt logic.

Parameters:
- HW, 9, hcount width
- VW, 9, vcount width
- H_TOTAL, 456, pixels per line
- H_ACTIVE, 336, visible pixels (hcount 0..H_ACTIVE-1)
- H_SYNC_START, 360, first hcount with HSYNC high
- H_SYNC_WIDTH, 32, HSYNC length in pixels
- V_TOTAL, 262, lines per frame
- V_ACTIVE, 240, visible lines
- V_SYNC_START, 244, first line with VSYNC high
- V_SYNC_WIDTH, 4, VSYNC length in lines
- NTAPS, 4, delayed-tap chain length
- TAP_BIT, 2, hcount bit fed into the tap chain (2 = 4H)

Ports:
- clk  in  1  system clock; one clock, all logic on its rising edge
- reset  in  1  synchronous, active-high reset
- pix_en  in  1  pixel-rate enable; counters and taps advance only when high
- hcount  out  HW  horizontal position
- vcount  out  VW  vertical position
- HSYNC  out  1  horizontal sync, active high
- VSYNC  out  1  vertical sync, active high
- HBLANK_b  out  1  low during horizontal blank
- VBLANK_b  out  1  low during vertical blank
- VBKINT_b  out  1  vertical-blank interrupt, active low, level-held
- VBKACK_b  in  1  interrupt acknowledge, active low
- frame_cnt  out  8  frame counter, wraps modulo 256
- taps  out  NTAPS  delayed copies of hcount[TAP_BIT]; taps[0] has the least delay
- line_cmp  in  VW  line-interrupt compare value (see Optional Feature)
- LINEINT_b  out  1  line interrupt, active low
- LINEACK_b  in  1  line-interrupt acknowledge, active low

Behaviour:
- Reset values: hcount=0, vcount=0, HSYNC=0, VSYNC=0, HBLANK_b=1, VBLANK_b=1, VBKINT_b=1, LINEINT_b=1, frame_cnt=0, taps=0.
- Reset takes priority over pix_en. Reset mid-frame returns to these values on the next edge.
- All outputs are registered. Sync and blank are decoded from the next counter values, so they change on the same edge as the counters (zero latency relative to hcount/vcount).
- When pix_en is high: if hcount==H_TOTAL-1, then hcount←0 and vcount advances; otherwise hcount+1.
- vcount advance: if vcount==V_TOTAL-1, then vcount←0 and frame_cnt+1; otherwise vcount+1.
- When pix_en is low, every register holds.
- HBLANK_b = (hcount < H_ACTIVE).
- VBLANK_b = (vcount < V_ACTIVE).
- HSYNC = H_SYNC_START ≤ hcount < H_SYNC_START+H_SYNC_WIDTH.
- VSYNC = V_SYNC_START ≤ vcount < V_SYNC_START+V_SYNC_WIDTH.
- VBKINT set event: a pix_en cycle in which vcount changes to V_ACTIVE.
  - On that edge VBKINT_b←0, and it stays low until VBKACK_b is sampled low on a clk edge.
  - It then returns to 1 on that edge. Ack does not depend on pix_en.
  - Set and ack on the same edge: set wins and VBKINT_b stays 0.
  - Ack with nothing pending has no effect. A second set while pending stays 0 (no counting).
- Tap chain: on a pix_en cycle with hcount[0]==0 (the 1H rising step), taps[0]←hcount[TAP_BIT] and taps[i]←taps[i-1].
- Elaboration checks (fatal): H_ACTIVE<H_TOTAL; H_SYNC_START+H_SYNC_WIDTH≤H_TOTAL; the same two checks for V; H_TOTAL≤2^HW; V_TOTAL≤2^VW; TAP_BIT<HW; NTAPS≥1.

Optional Feature:
Macro VTG_LINE_IRQ_EN.
- Defined: LINEINT_b←0 on the pix_en edge where vcount changes to line_cmp. line_cmp is sampled at that edge. The handshake with LINEACK_b is identical to VBKINT/VBKACK, including the set-wins rule.
- Undefined: LINEINT_b is constant 1, and line_cmp and LINEACK_b are ignored. The ports remain in both builds.

Decomposition:
- Package vtg_pkg holds:
  - default geometry constants (H_TOTAL_DEF etc.)
  - typedefs hcount_t and vcount_t
  - the frame_cnt width constant
- One sub-module, irq_latch: set/ack active-low level latch with set priority, instantiated for VBKINT and LINEINT.

Test Plan:
1. Reset, then pix_en held high for 456 cycles → hcount reaches 455 then 0; vcount 0→1; HBLANK_b falls at hcount 336; HSYNC high for hcount 360..391.
2. Run one full frame with defaults (456×262 enables) → vcount wraps 261→0, frame_cnt=1; VBLANK_b low for lines 240..261; VSYNC high for lines 244..247.
3. VBKINT handshake → VBKINT_b falls on the edge vcount becomes 240 and stays low for 1000 clocks. Then VBKACK_b pulsed low for one clk → VBKINT_b=1 on that edge. Ack asserted on the exact set edge → VBKINT_b stays 0.
4. pix_en toggled 1-of-4 cycles with reset asserted at vcount=100, hcount=200 → all outputs return to reset values the next edge; counters hold on non-enable cycles.
5. Taps with TAP_BIT=2, NTAPS=4 → taps[0] toggles every 4 hcount steps; taps[3] lags taps[0] by 3 tap-shift events.
6. VTG_LINE_IRQ_EN defined, line_cmp=32 → LINEINT_b falls on the edge vcount becomes 32 and clears on LINEACK_b. Build without the macro → LINEINT_b constant 1.

Source files
------------

// File: rtl/video_timing_gen_pkg.sv
// Shared defaults and types for the raster timing generator.
// Geometry defaults match the original fixed-geometry sync block.
package vtg_pkg;

    localparam int unsigned HW_DEF           = 9;
    localparam int unsigned VW_DEF           = 9;
    localparam int unsigned H_TOTAL_DEF      = 456;
    localparam int unsigned H_ACTIVE_DEF     = 336;
    localparam int unsigned H_SYNC_START_DEF = 360;
    localparam int unsigned H_SYNC_WIDTH_DEF = 32;
    localparam int unsigned V_TOTAL_DEF      = 262;
    localparam int unsigned V_ACTIVE_DEF     = 240;
    localparam int unsigned V_SYNC_START_DEF = 244;
    localparam int unsigned V_SYNC_WIDTH_DEF = 4;
    localparam int unsigned NTAPS_DEF        = 4;
    localparam int unsigned TAP_BIT_DEF      = 2;

    localparam int unsigned FRAME_W = 8;

    typedef logic [HW_DEF-1:0] hcount_t;
    typedef logic [VW_DEF-1:0] vcount_t;

endpackage

// File: rtl/video_timing_gen_irq_latch.sv
// Active-low level interrupt latch: set forces low, ack (active low) releases,
// set wins when both occur on the same edge.
module irq_latch (
    input  logic clk,
    input  logic reset,
    input  logic set,
    input  logic ack_b,
    output logic irq_b
);

    always_ff @(posedge clk) begin
        if (reset)
            irq_b <= 1'b1;
        else if (set)
            irq_b <= 1'b0;
        else if (!ack_b)
            irq_b <= 1'b1;
    end

endmodule

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: counters, sync/blank, VBL interrupt,
// frame counter and hcount tap chain. Optional line interrupt: VTG_LINE_IRQ_EN.
module video_timing_gen
    import vtg_pkg::*;
#(
    parameter int unsigned HW           = HW_DEF,
    parameter int unsigned VW           = VW_DEF,
    parameter int unsigned H_TOTAL      = H_TOTAL_DEF,
    parameter int unsigned H_ACTIVE     = H_ACTIVE_DEF,
    parameter int unsigned H_SYNC_START = H_SYNC_START_DEF,
    parameter int unsigned H_SYNC_WIDTH = H_SYNC_WIDTH_DEF,
    parameter int unsigned V_TOTAL      = V_TOTAL_DEF,
    parameter int unsigned V_ACTIVE     = V_ACTIVE_DEF,
    parameter int unsigned V_SYNC_START = V_SYNC_START_DEF,
    parameter int unsigned V_SYNC_WIDTH = V_SYNC_WIDTH_DEF,
    parameter int unsigned NTAPS        = NTAPS_DEF,
    parameter int unsigned TAP_BIT      = TAP_BIT_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pix_en,
    output logic [HW-1:0]      hcount,
    output logic [VW-1:0]      vcount,
    output logic               HSYNC,
    output logic               VSYNC,
    output logic               HBLANK_b,
    output logic               VBLANK_b,
    output logic               VBKINT_b,
    input  logic               VBKACK_b,
    output logic [FRAME_W-1:0] frame_cnt,
    output logic [NTAPS-1:0]   taps,
    input  logic [VW-1:0]      line_cmp,
    output logic               LINEINT_b,
    input  logic               LINEACK_b
);

    generate
        if (H_ACTIVE >= H_TOTAL) begin : g_bad_hact
            $fatal(1, "video_timing_gen: H_ACTIVE must be below H_TOTAL");
        end
        if (H_SYNC_START + H_SYNC_WIDTH > H_TOTAL) begin : g_bad_hsync
            $fatal(1, "video_timing_gen: HSYNC extends past H_TOTAL");
        end
        if (V_ACTIVE >= V_TOTAL) begin : g_bad_vact
            $fatal(1, "video_timing_gen: V_ACTIVE must be below V_TOTAL");
        end
        if (V_SYNC_START + V_SYNC_WIDTH > V_TOTAL) begin : g_bad_vsync
            $fatal(1, "video_timing_gen: VSYNC extends past V_TOTAL");
        end
        if (longint'(H_TOTAL) > (64'd1 << HW)) begin : g_bad_hw
            $fatal(1, "video_timing_gen: H_TOTAL does not fit in HW bits");
        end
        if (longint'(V_TOTAL) > (64'd1 << VW)) begin : g_bad_vw
            $fatal(1, "video_timing_gen: V_TOTAL does not fit in VW bits");
        end
        if (TAP_BIT >= HW) begin : g_bad_tapbit
            $fatal(1, "video_timing_gen: TAP_BIT must be below HW");
        end
        if (NTAPS < 1) begin : g_bad_ntaps
            $fatal(1, "video_timing_gen: NTAPS must be at least 1");
        end
    endgenerate

    logic             h_wrap;
    logic             v_wrap;
    logic [HW-1:0]    h_nxt;
    logic [VW-1:0]    v_nxt;
    logic [31:0]      h_nxt32;
    logic [31:0]      v_nxt32;
    logic [NTAPS-1:0] taps_nxt;
    logic             vbk_set;

    always_comb begin
        h_wrap  = (hcount == HW'(H_TOTAL - 1));
        v_wrap  = (vcount == VW'(V_TOTAL - 1));
        h_nxt   = h_wrap ? '0 : hcount + HW'(1);
        v_nxt   = vcount;
        if (h_wrap)
            v_nxt = v_wrap ? '0 : vcount + VW'(1);
        h_nxt32 = 32'(h_nxt);
        v_nxt32 = 32'(v_nxt);
        // Taps shift only on the even-hcount steps, sampling hcount before it advances.
        taps_nxt = taps;
        if (!hcount[0]) begin
            taps_nxt[0] = hcount[TAP_BIT];
            for (int unsigned i = 1; i < NTAPS; i++)
                taps_nxt[i] = taps[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hcount    <= '0;
            vcount    <= '0;
            frame_cnt <= '0;
            HSYNC     <= 1'b0;
            VSYNC     <= 1'b0;
            HBLANK_b  <= 1'b1;
            VBLANK_b  <= 1'b1;
            taps      <= '0;
        end else if (pix_en) begin
            hcount   <= h_nxt;
            vcount   <= v_nxt;
            if (h_wrap && v_wrap)
                frame_cnt <= frame_cnt + FRAME_W'(1);
            // Decoded from the next counts so sync/blank line up with the counters.
            HBLANK_b <= (h_nxt32 < H_ACTIVE);
            VBLANK_b <= (v_nxt32 < V_ACTIVE);
            HSYNC    <= (h_nxt32 >= H_SYNC_START) && (h_nxt32 < H_SYNC_START + H_SYNC_WIDTH);
            VSYNC    <= (v_nxt32 >= V_SYNC_START) && (v_nxt32 < V_SYNC_START + V_SYNC_WIDTH);
            taps     <= taps_nxt;
        end
    end

    assign vbk_set = pix_en && h_wrap && (v_nxt == VW'(V_ACTIVE));

    irq_latch u_vbk_irq (
        .clk   (clk),
        .reset (reset),
        .set   (vbk_set),
        .ack_b (VBKACK_b),
        .irq_b (VBKINT_b)
    );

`ifdef VTG_LINE_IRQ_EN
    logic line_set;

    assign line_set = pix_en && h_wrap && (v_nxt == line_cmp);

    irq_latch u_line_irq (
        .clk   (clk),
        .reset (reset),
        .set   (line_set),
        .ack_b (LINEACK_b),
        .irq_b (LINEINT_b)
    );
`else
    logic unused_line;

    assign LINEINT_b   = 1'b1;
    assign unused_line = ^{line_cmp, LINEACK_b};
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Self-checking bench for video_timing_gen on a reduced geometry; the model
// derives every output from the count of enabled pixels since reset.
module tb_video_timing_gen;
    import vtg_pkg::*;

    localparam int unsigned HT   = 16;
    localparam int unsigned HA   = 11;
    localparam int unsigned HSS  = 12;
    localparam int unsigned HSW  = 4;
    localparam int unsigned VT   = 10;
    localparam int unsigned VA   = 7;
    localparam int unsigned VSS  = 8;
    localparam int unsigned VSW  = 2;
    localparam int unsigned NT   = 4;
    localparam int unsigned TB   = 2;
    localparam int unsigned LCMP = 3;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           pix_en = 1'b0;
    logic           VBKACK_b = 1'b1;
    logic           LINEACK_b = 1'b1;
    vcount_t        line_cmp = vcount_t'(LCMP);
    hcount_t        hcount;
    vcount_t        vcount;
    logic           HSYNC, VSYNC, HBLANK_b, VBLANK_b, VBKINT_b, LINEINT_b;
    logic [FRAME_W-1:0] frame_cnt;
    logic [NT-1:0]  taps;

    int checks = 0;
    int failures = 0;

    video_timing_gen #(
        .HW(HW_DEF), .VW(VW_DEF),
        .H_TOTAL(HT), .H_ACTIVE(HA), .H_SYNC_START(HSS), .H_SYNC_WIDTH(HSW),
        .V_TOTAL(VT), .V_ACTIVE(VA), .V_SYNC_START(VSS), .V_SYNC_WIDTH(VSW),
        .NTAPS(NT), .TAP_BIT(TB)
    ) dut (
        .clk(clk), .reset(reset), .pix_en(pix_en),
        .hcount(hcount), .vcount(vcount),
        .HSYNC(HSYNC), .VSYNC(VSYNC), .HBLANK_b(HBLANK_b), .VBLANK_b(VBLANK_b),
        .VBKINT_b(VBKINT_b), .VBKACK_b(VBKACK_b), .frame_cnt(frame_cnt),
        .taps(taps), .line_cmp(line_cmp), .LINEINT_b(LINEINT_b), .LINEACK_b(LINEACK_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d time=%0t", name, act, exp, $time);
        end
    endtask

    // Model state: pixels since reset, pending interrupts, recent tap samples.
    longint n = 0;
    bit     m_valid = 1'b0;
    bit     m_vbk = 1'b0;
    bit     m_lin = 1'b0;
    bit     hist[$];
    bit     vset, lset;
    longint ln;

    always @(posedge clk) begin
        if (reset) begin
            n = 0;
            m_vbk = 1'b0;
            m_lin = 1'b0;
            hist.delete();
            m_valid = 1'b1;
        end else if (m_valid) begin
            vset = 1'b0;
            lset = 1'b0;
            if (pix_en) begin
                if ((n % HT) % 2 == 0) begin
                    hist.push_front(bit'(((n % HT) / (64'd1 << TB)) % 2));
                    if (hist.size() > NT) void'(hist.pop_back());
                end
                n++;
                if (n % HT == 0) begin
                    ln = (n / HT) % VT;
                    vset = (ln == VA);
`ifdef VTG_LINE_IRQ_EN
                    lset = (ln == longint'(line_cmp));
`endif
                end
            end
            if (vset) m_vbk = 1'b1;
            else if (!VBKACK_b) m_vbk = 1'b0;
            if (lset) m_lin = 1'b1;
            else if (!LINEACK_b) m_lin = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            longint h, v, et;
            h = n % HT;
            v = (n / HT) % VT;
            et = 0;
            for (int k = 0; k < NT; k++)
                if (k < hist.size() && hist[k]) et |= (64'd1 << k);
            chk("hcount", longint'(hcount), h);
            chk("vcount", longint'(vcount), v);
            chk("frame_cnt", longint'(frame_cnt), (n / (HT * VT)) % 256);
            chk("HBLANK_b", longint'(HBLANK_b), longint'(h < HA));
            chk("VBLANK_b", longint'(VBLANK_b), longint'(v < VA));
            chk("HSYNC", longint'(HSYNC), longint'(h >= HSS && h < HSS + HSW));
            chk("VSYNC", longint'(VSYNC), longint'(v >= VSS && v < VSS + VSW));
            chk("VBKINT_b", longint'(VBKINT_b), longint'(!m_vbk));
            chk("LINEINT_b", longint'(LINEINT_b), longint'(!m_lin));
            chk("taps", longint'(taps), et);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_hcount"}, longint'(hcount), 0);
        chk({tag, "_vcount"}, longint'(vcount), 0);
        chk({tag, "_HSYNC"}, longint'(HSYNC), 0);
        chk({tag, "_VSYNC"}, longint'(VSYNC), 0);
        chk({tag, "_HBLANK_b"}, longint'(HBLANK_b), 1);
        chk({tag, "_VBLANK_b"}, longint'(VBLANK_b), 1);
        chk({tag, "_VBKINT_b"}, longint'(VBKINT_b), 1);
        chk({tag, "_LINEINT_b"}, longint'(LINEINT_b), 1);
        chk({tag, "_frame_cnt"}, longint'(frame_cnt), 0);
        chk({tag, "_taps"}, longint'(taps), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        pix_en = 1'b0;
        repeat (3) tick();
        check_reset("rst0");

        // Line timing and taps
        reset = 1'b0;
        pix_en = 1'b1;
        repeat (7) tick();
        chk("t7_hcount", longint'(hcount), 7);
        chk("t7_taps", longint'(taps), 3);
        repeat (2) tick();
        chk("t9_hcount", longint'(hcount), 9);
        chk("t9_taps", longint'(taps), 6);
        repeat (2) tick();
        chk("h11_hcount", longint'(hcount), 11);
        chk("h11_HBLANK_b", longint'(HBLANK_b), 0);
        chk("h11_HSYNC", longint'(HSYNC), 0);
        tick();
        chk("h12_HSYNC", longint'(HSYNC), 1);
        repeat (3) tick();
        chk("h15_hcount", longint'(hcount), 15);
        chk("h15_HSYNC", longint'(HSYNC), 1);
        tick();
        chk("wrap_hcount", longint'(hcount), 0);
        chk("wrap_vcount", longint'(vcount), 1);
        chk("wrap_HSYNC", longint'(HSYNC), 0);
        chk("wrap_HBLANK_b", longint'(HBLANK_b), 1);

        // Vertical blank interrupt
        repeat (95) tick();
        chk("pre_vbl_vcount", longint'(vcount), 6);
        chk("pre_vbl_VBKINT_b", longint'(VBKINT_b), 1);
        tick();
        chk("vbl_vcount", longint'(vcount), 7);
        chk("vbl_VBKINT_b", longint'(VBKINT_b), 0);
        chk("vbl_VBLANK_b", longint'(VBLANK_b), 0);
        pix_en = 1'b0;
        repeat (1000) tick();
        chk("held_VBKINT_b", longint'(VBKINT_b), 0);
        chk("held_hcount", longint'(hcount), 0);
        VBKACK_b = 1'b0;
        tick();
        VBKACK_b = 1'b1;
        chk("ack_VBKINT_b", longint'(VBKINT_b), 1);

        // Vertical sync and frame wrap
        pix_en = 1'b1;
        repeat (16) tick();
        chk("vs_vcount", longint'(vcount), 8);
        chk("vs_VSYNC", longint'(VSYNC), 1);
        repeat (31) tick();
        chk("last_vcount", longint'(vcount), 9);
        chk("last_VSYNC", longint'(VSYNC), 1);
        tick();
        chk("frame1_vcount", longint'(vcount), 0);
        chk("frame1_frame_cnt", longint'(frame_cnt), 1);
        chk("frame1_VSYNC", longint'(VSYNC), 0);
        chk("frame1_VBLANK_b", longint'(VBLANK_b), 1);

        // Ack on the set edge: set wins
        repeat (111) tick();
        VBKACK_b = 1'b0;
        tick();
        chk("setwins_VBKINT_b", longint'(VBKINT_b), 0);
        VBKACK_b = 1'b1;
        pix_en = 1'b0;
        tick();
        chk("setwins_hold_VBKINT_b", longint'(VBKINT_b), 0);
        VBKACK_b = 1'b0;
        tick();
        VBKACK_b = 1'b1;
        chk("ack2_VBKINT_b", longint'(VBKINT_b), 1);
        VBKACK_b = 1'b0;
        tick();
        VBKACK_b = 1'b1;
        chk("idle_ack_VBKINT_b", longint'(VBKINT_b), 1);

        // Sparse enables then mid-frame reset
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int c = 0; c < 2000 && !(hcount == 10 && vcount == 5); c++) begin
            pix_en = (c % 4 == 0);
            tick();
        end
        chk("sparse_hcount", longint'(hcount), 10);
        chk("sparse_vcount", longint'(vcount), 5);
        pix_en = 1'b0;
        tick();
        chk("sparse_hold_hcount", longint'(hcount), 10);
        reset = 1'b1;
        pix_en = 1'b1;
        tick();
        check_reset("midrst");
        reset = 1'b0;

        // Line interrupt
        repeat (47) tick();
        chk("pre_line_LINEINT_b", longint'(LINEINT_b), 1);
        tick();
        chk("line_vcount", longint'(vcount), 3);
`ifdef VTG_LINE_IRQ_EN
        chk("line_LINEINT_b", longint'(LINEINT_b), 0);
`else
        chk("line_LINEINT_b", longint'(LINEINT_b), 1);
`endif
        pix_en = 1'b0;
        LINEACK_b = 1'b0;
        tick();
        LINEACK_b = 1'b1;
        chk("lineack_LINEINT_b", longint'(LINEINT_b), 1);

        // Frame counter modulo 256, with periodic acks
        reset = 1'b1;
        tick();
        reset = 1'b0;
        pix_en = 1'b1;
        for (int c = 0; c < 255 * 160; c++) begin
            VBKACK_b  = (c % 37 == 0) ? 1'b0 : 1'b1;
            LINEACK_b = (c % 53 == 0) ? 1'b0 : 1'b1;
            tick();
        end
        VBKACK_b = 1'b1;
        LINEACK_b = 1'b1;
        chk("f255_frame_cnt", longint'(frame_cnt), 255);
        chk("f255_vcount", longint'(vcount), 0);
        repeat (160) tick();
        chk("f256_frame_cnt", longint'(frame_cnt), 0);
        chk("f256_hcount", longint'(hcount), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
